execute_pipe: RTL and testbench

Parametrised execute stage for the pipelined core. It selects each ALU operand from the register file, the MEM forwarding path, the WB forwarding path or an immediate, and computes one result per instruction. The result and the status flags are registered. Single-cycle ops have a latency of one cycle. MUL is an iterative shift-add and stalls issue through a valid/ready handshake.

---
 rtl/execute_pipe_if.sv | 33 +++
 rtl/execute_pipe.sv | 162 ++++++++++++++++
 tb/tb_execute_pipe.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_pipe_if.sv
// Issue/result bundle between the operand-select front end and execute_pipe.
// The master drives instructions; the slave (execute stage) returns results and flags.
interface execute_pipe_if #(
  parameter int WIDTH = 24
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [1:0]       reg1_sel;
  logic [1:0]       reg2_sel;
  logic [WIDTH-1:0] reg1;
  logic [WIDTH-1:0] reg2;
  logic [WIDTH-1:0] mem_result;
  logic [WIDTH-1:0] wb_result;
  logic [WIDTH-1:0] imm;
  logic             flags_we;
  logic             out_valid;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       flags;

  modport master (
    output flush, in_valid, op, reg1_sel, reg2_sel, reg1, reg2,
           mem_result, wb_result, imm, flags_we,
    input  in_ready, out_valid, alu_result, flags
  );

  modport slave (
    input  flush, in_valid, op, reg1_sel, reg2_sel, reg1, reg2,
           mem_result, wb_result, imm, flags_we,
    output in_ready, out_valid, alu_result, flags
  );
endinterface

// File: rtl/execute_pipe.sv
// Execute stage: forwarding operand mux, single-cycle ALU with registered result/flags,
// and an iterative shift-add multiplier that holds off issue while it runs.
module execute_pipe #(
  parameter int WIDTH = 24,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           rst,
  execute_pipe_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [SH_W:0]    SH_LIM   = (SH_W + 1)'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,
                         OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_SHL = 4'd5,
                         OP_SHR = 4'd6,  OP_SRA = 4'd7,  OP_MUL = 4'd8,
                         OP_CMP = 4'd9,  OP_MOV = 4'd10;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q;
  logic             in_ready_q, out_valid_q, fwe_q;
  logic [WIDTH-1:0] result_q, a_q, b_q, acc_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] opa, opb, alu_res, mul_sum;
  logic             alu_c, alu_v, alu_rsv, sh_big;
  logic [SH_W-1:0]  sh;
  logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext, sra_ext;

  always_comb begin
    case (bus.reg1_sel)
      2'd0:    opa = bus.reg1;
      2'd1:    opa = bus.mem_result;
      2'd2:    opa = bus.wb_result;
      default: opa = bus.imm;
    endcase
    case (bus.reg2_sel)
      2'd0:    opb = bus.reg2;
      2'd1:    opb = bus.mem_result;
      2'd2:    opb = bus.wb_result;
      default: opb = bus.imm;
    endcase
  end

  // Shifts carry an extra bit on the exit side so the last bit shifted out is C.
  assign sh      = opb[SH_W-1:0];
  assign sh_big  = {1'b0, sh} >= SH_LIM;
  assign add_ext = {1'b0, opa} + {1'b0, opb};
  assign sub_ext = {1'b0, opa} - {1'b0, opb};
  assign shl_ext = {1'b0, opa} << sh;
  assign shr_ext = {opa, 1'b0} >> sh;
  assign sra_ext = $signed({opa, 1'b0}) >>> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_rsv = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (add_ext[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = ~sub_ext[WIDTH];
        alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (sub_ext[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_XOR: alu_res = opa ^ opb;
      OP_SHL: if (!sh_big) begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: if (!sh_big) begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      OP_SRA: begin
        if (sh_big) alu_res = {WIDTH{opa[WIDTH-1]}};
        else begin
          alu_res = sra_ext[WIDTH:1];
          alu_c   = sra_ext[0];
        end
      end
      OP_MOV: alu_res = opb;
      OP_MUL: alu_res = '0;
      default: alu_rsv = 1'b1;
    endcase
  end

  // a_q shifts left and b_q right each iteration, so b_q[0] is always the current multiplier bit.
  assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      fwe_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.in_valid && !bus.flush) begin
          if (bus.op == OP_MUL) begin
            a_q        <= opa;
            b_q        <= opb;
            acc_q      <= '0;
            cnt_q      <= '0;
            fwe_q      <= bus.flags_we;
            state_q    <= S_MUL;
            in_ready_q <= 1'b0;
          end else begin
            result_q    <= alu_res;
            out_valid_q <= 1'b1;
            if (bus.flags_we && !alu_rsv)
              flags_q <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
          end
        end
        S_MUL: begin
          if (bus.flush) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
          end else if (cnt_q == CNT_LAST) begin
            result_q    <= mul_sum;
            out_valid_q <= 1'b1;
            if (fwe_q) flags_q <= {mul_sum[WIDTH-1], mul_sum == '0, 2'b00};
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
          end else begin
            acc_q <= mul_sum;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign bus.flags      = flags_q;
endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: an arithmetic reference model checked every cycle,
// plus hand-computed literal expectations for the key vectors.
module tb_execute_pipe;
  localparam int W  = 24;
  localparam int SH = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_pipe_if #(.WIDTH(W)) bus();
  execute_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] r,
                                        input logic [W-1:0] m, input logic [W-1:0] w,
                                        input logic [W-1:0] i);
    case (s)
      2'd0: return r;
      2'd1: return m;
      2'd2: return w;
      default: return i;
    endcase
  endfunction

  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic v,
                                  output logic upd);
    longint ua, ub, sa, sb, t, lim;
    int s;
    ua  = longint'(a);
    ub  = longint'(b);
    lim = longint'(1) << (W - 1);
    sa  = a[W-1] ? ua - 2 * lim : ua;
    sb  = b[W-1] ? ub - 2 * lim : ub;
    s   = int'(b[SH-1:0]);
    r = '0; c = 1'b0; v = 1'b0; upd = 1'b1;
    case (op)
      4'd0: begin
        t = ua + ub; c = t[W];
        t = sa + sb; v = (t >= lim) || (t < -lim);
        r = W'(ua + ub);
      end
      4'd1, 4'd9: begin
        c = (ua >= ub);
        t = sa - sb; v = (t >= lim) || (t < -lim);
        r = W'(ua - ub);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: if (s == 0) r = a;
            else if (s < W) begin
              r = W'(ua * (longint'(1) << s));
              c = ((ua >> (W - s)) & 1) != 0;
            end
      4'd6: if (s == 0) r = a;
            else if (s < W) begin
              r = W'(ua / (longint'(1) << s));
              c = ((ua >> (s - 1)) & 1) != 0;
            end
      4'd7: if (s == 0) r = a;
            else if (s < W) begin
              r = W'(sa >>> s);
              c = ((ua >> (s - 1)) & 1) != 0;
            end else r = a[W-1] ? '1 : '0;
      4'd8: r = W'(ua * ub);
      4'd10: r = b;
      default: upd = 1'b0;
    endcase
  endfunction

  int           m_busy;
  logic         m_ov, m_mfwe;
  logic [W-1:0] m_res, m_mul;
  logic [3:0]   m_flg;

  initial begin : model
    logic [W-1:0] a, b, r;
    logic         c, v, u;
    m_busy = 0; m_ov = 1'b0; m_mfwe = 1'b0; m_res = '0; m_mul = '0; m_flg = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_ov = 1'b0; m_res = '0; m_flg = '0;
      end else begin
        m_ov = 1'b0;
        if (m_busy > 0) begin
          if (bus.flush) m_busy = 0;
          else begin
            m_busy--;
            if (m_busy == 0) begin
              m_ov = 1'b1; m_res = m_mul;
              if (m_mfwe) m_flg = {m_mul[W-1], m_mul == '0, 2'b00};
            end
          end
        end else if (bus.in_valid && !bus.flush) begin
          a = pick(bus.reg1_sel, bus.reg1, bus.mem_result, bus.wb_result, bus.imm);
          b = pick(bus.reg2_sel, bus.reg2, bus.mem_result, bus.wb_result, bus.imm);
          ref_alu(bus.op, a, b, r, c, v, u);
          if (bus.op == 4'd8) begin
            m_busy = W; m_mul = r; m_mfwe = bus.flags_we;
          end else begin
            m_ov = 1'b1; m_res = r;
            if (bus.flags_we && u) m_flg = {r[W-1], r == '0, c, v};
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      check("model.out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("model.in_ready", 32'(bus.in_ready), 32'(m_busy == 0));
      check("model.alu_result", 32'(bus.alu_result), 32'(m_res));
      check("model.flags", 32'(bus.flags), 32'(m_flg));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [3:0] op, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [W-1:0] mr,
                       input logic [W-1:0] wr, input logic [W-1:0] im, input logic fwe);
    bus.op = op; bus.reg1_sel = s1; bus.reg2_sel = s2;
    bus.reg1 = r1; bus.reg2 = r2; bus.mem_result = mr; bus.wb_result = wr; bus.imm = im;
    bus.flags_we = fwe; bus.in_valid = 1'b1;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] res, input logic [3:0] flg);
    @(negedge clk);
    check({nm, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({nm, ".result"}, 32'(bus.alu_result), 32'(res));
    check({nm, ".flags"}, 32'(bus.flags), 32'(flg));
  endtask

  task automatic no_pulses(input string nm, input int cycles);
    int p;
    p = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.out_valid) p++;
    end
    check(nm, 32'(p), 32'd0);
  endtask

  initial begin : stim
    int k, lo, p;
    rst = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0; bus.reg1_sel = '0; bus.reg2_sel = '0;
    bus.reg1 = '0; bus.reg2 = '0; bus.mem_result = '0; bus.wb_result = '0; bus.imm = '0;
    bus.flags_we = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    check("reset.result", 32'(bus.alu_result), 32'd0);
    check("reset.flags", 32'(bus.flags), 32'd0);

    issue(4'd0, 2'd0, 2'd0, 24'd5, 24'd10, '0, '0, '0, 1'b1);
    expect_out("add", 24'd15, 4'b0000);
    issue(4'd1, 2'd0, 2'd0, 24'd5, 24'd10, '0, '0, '0, 1'b1);
    expect_out("sub_neg", 24'hFFFFFB, 4'b1000);
    issue(4'd1, 2'd0, 2'd0, 24'd10, 24'd5, '0, '0, '0, 1'b1);
    expect_out("sub_pos", 24'd5, 4'b0010);
    issue(4'd9, 2'd0, 2'd0, 24'd7, 24'd7, '0, '0, '0, 1'b1);
    expect_out("cmp_eq", 24'd0, 4'b0110);

    issue(4'd0, 2'd1, 2'd2, '0, '0, 24'h7FFFFF, 24'd1, '0, 1'b1);
    expect_out("fwd_add", 24'h800000, 4'b1001);
    issue(4'd0, 2'd0, 2'd0, 24'd5, 24'd10, '0, '0, '0, 1'b1);
    expect_out("add_again", 24'd15, 4'b0000);
    issue(4'd0, 2'd1, 2'd2, '0, '0, 24'h7FFFFF, 24'd1, '0, 1'b0);
    expect_out("fwd_add_nowe", 24'h800000, 4'b0000);

    // MUL with a following ADD held on in_valid throughout
    bus.op = 4'd8; bus.reg1_sel = 2'd0; bus.reg2_sel = 2'd0;
    bus.reg1 = 24'h000123; bus.reg2 = 24'h000010; bus.flags_we = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #2;
    bus.op = 4'd0; bus.reg1 = 24'd1; bus.reg2 = 24'd2;
    k = 0; lo = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 40) begin
      if (!bus.in_ready) lo++;
      k++;
      @(negedge clk);
    end
    check("mul.latency", 32'(k), 32'd24);
    check("mul.ready_low", 32'(lo), 32'd24);
    check("mul.result", 32'(bus.alu_result), 32'h001230);
    check("mul.flags", 32'(bus.flags), 32'd0);
    check("mul.ready_back", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    p = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) begin
        p++;
        check("held_add.result", 32'(bus.alu_result), 32'd3);
      end
    end
    check("held_add.pulses", 32'(p), 32'd1);

    issue(4'd5, 2'd0, 2'd0, 24'd1, 24'd23, '0, '0, '0, 1'b1);
    expect_out("shl23", 24'h800000, 4'b1000);
    issue(4'd6, 2'd0, 2'd0, 24'd3, 24'd1, '0, '0, '0, 1'b1);
    expect_out("shr1", 24'd1, 4'b0010);
    issue(4'd7, 2'd0, 2'd3, 24'h800000, '0, '0, '0, 24'd30, 1'b1);
    expect_out("sra30", 24'hFFFFFF, 4'b1000);
    issue(4'd12, 2'd0, 2'd0, 24'd5, 24'd9, '0, '0, '0, 1'b1);
    expect_out("reserved", 24'd0, 4'b1000);

    // back-to-back issue every cycle
    bus.reg1_sel = 2'd0; bus.reg2_sel = 2'd0; bus.flags_we = 1'b1; bus.in_valid = 1'b1;
    bus.op = 4'd0; bus.reg1 = 24'd1; bus.reg2 = 24'd1;
    @(posedge clk); #2;
    bus.reg1 = 24'd2; bus.reg2 = 24'd2;
    @(posedge clk); #2;
    bus.op = 4'd1; bus.reg1 = 24'd9; bus.reg2 = 24'd4;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b.result", 32'(bus.alu_result), 32'd5);
    check("b2b.flags", 32'(bus.flags), 32'b0010);

    // flush beats in_valid in IDLE
    bus.flush = 1'b1;
    issue(4'd0, 2'd0, 2'd0, 24'd1, 24'd1, '0, '0, '0, 1'b1);
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_idle.out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_idle.result", 32'(bus.alu_result), 32'd5);

    // flush five cycles into a MUL
    issue(4'd8, 2'd0, 2'd0, 24'd3, 24'd4, '0, '0, '0, 1'b1);
    repeat (4) @(posedge clk);
    #2 bus.flush = 1'b1;
    @(posedge clk); #2;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_mul.in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_mul.out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_mul.flags", 32'(bus.flags), 32'b0010);
    no_pulses("flush_mul.no_pulse", 30);

    // reset ten cycles into a MUL
    issue(4'd8, 2'd0, 2'd0, 24'd3, 24'd4, '0, '0, '0, 1'b1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_mul.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mul.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mul.result", 32'(bus.alu_result), 32'd0);
    check("rst_mul.flags", 32'(bus.flags), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    no_pulses("rst_mul.no_pulse", 30);

    issue(4'd0, 2'd0, 2'd0, 24'd2, 24'd3, '0, '0, '0, 1'b1);
    expect_out("post_rst_add", 24'd5, 4'b0000);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
